// File: rtl/inst_encoder_if.sv
// Encoder bus: the input field handshake and the registered output handshake.
//   in_valid/in_ready + decoded fields (fmt, opcode, rd, rs1, rs2, funct3, funct7, imm)
//   out_valid/out_ready + out_inst, out_addr, out_err, err_code, err_cnt
// slave  : the encoder side
// master : the producer/consumer side (loader or bench)
interface inst_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic [1:0]        err_code;
  logic [7:0]        err_cnt;

  modport slave (
    input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err, err_code, err_cnt
  );

  modport master (
    output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err, err_code, err_cnt
  );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I fields into a 32-bit instruction word,
// checks the immediate for range/alignment and stamps each word with a
// sequential IMEM byte address. One registered output stage.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active low
//   clear  synchronous restart: address to BASE_ADDR, err_cnt to 0, drop output
//   bus    inst_encoder_if.slave (input fields handshake, output word handshake)
module inst_encoder #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  inst_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
    FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0, ERR_RANGE = 2'd1, ERR_ALIGN = 2'd2, ERR_FMT = 2'd3
  } err_e;

  logic              valid_q, valid_d;
  logic [31:0]       inst_q, inst_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [31:0] enc_inst;
  logic [1:0]  enc_code;
  logic        accept, xfer;

  assign bus.in_ready = !clear && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = valid_q && bus.out_ready;

  // Field packing and immediate checks. A word with a bad immediate is still
  // packed from the truncated bits so the consumer sees what was encoded.
  always_comb begin
    logic [31:0] im;
    im       = bus.imm;
    enc_inst = '0;
    enc_code = ERR_NONE;
    case (bus.fmt)
      FMT_R: enc_inst = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      FMT_I: begin
        enc_inst = {im[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        if (im != {{20{im[11]}}, im[11:0]}) enc_code = ERR_RANGE;
      end
      FMT_S: begin
        enc_inst = {im[11:5], bus.rs2, bus.rs1, bus.funct3, im[4:0], bus.opcode};
        if (im != {{20{im[11]}}, im[11:0]}) enc_code = ERR_RANGE;
      end
      FMT_B: begin
        enc_inst = {im[12], im[10:5], bus.rs2, bus.rs1, bus.funct3, im[4:1], im[11],
                    bus.opcode};
        if (im[0])                               enc_code = ERR_ALIGN;
        else if (im != {{19{im[12]}}, im[12:0]}) enc_code = ERR_RANGE;
      end
      FMT_U: begin
        enc_inst = {im[31:12], bus.rd, bus.opcode};
        if (im[11:0] != 12'd0) enc_code = ERR_RANGE;
      end
      FMT_J: begin
        enc_inst = {im[20], im[10:1], im[11], im[19:12], bus.rd, bus.opcode};
        if (im[0])                               enc_code = ERR_ALIGN;
        else if (im != {{11{im[20]}}, im[20:0]}) enc_code = ERR_RANGE;
      end
      default: begin
        enc_inst = 32'h0000_0013; // NOP keeps the loaded program executable
        enc_code = ERR_FMT;
      end
    endcase
  end

  // addr_q always holds the address of the word currently (or next) on the
  // output, so it only advances when a word leaves.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    err_d   = err_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    if (clear) begin
      valid_d = 1'b0;
      addr_d  = BASE_ADDR;
      cnt_d   = 8'd0;
    end else begin
      if (xfer) begin
        valid_d = 1'b0;
        addr_d  = addr_q + ADDR_W'(4);
        if (err_q && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
      if (accept) begin
        valid_d = 1'b1;
        inst_d  = enc_inst;
        err_d   = (enc_code != ERR_NONE);
        code_d  = enc_code;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      cnt_q   <= 8'd0;
      addr_q  <= BASE_ADDR;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_inst  = inst_q;
  assign bus.out_err   = err_q;
  assign bus.err_code  = code_q;
  assign bus.err_cnt   = cnt_q;
  assign bus.out_addr  = addr_q;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  inst_encoder_if #(.ADDR_W(AW)) bus ();

  inst_encoder #(.ADDR_W(AW), .BASE_ADDR(4'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   inst;
    logic [AW-1:0] addr;
    logic          err;
    logic [1:0]    code;
  } exp_t;

  exp_t          q[$];
  logic [AW-1:0] exp_addr = '0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a transfer is visible at the negedge before the edge
  // that completes it.
  always @(negedge clk) begin
    if (rst_n && !clear && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%08h expected none", bus.out_inst);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_inst", bus.out_inst, e.inst);
        chk("out_addr", 32'(bus.out_addr), 32'(e.addr));
        chk("out_err", 32'(bus.out_err), 32'(e.err));
        chk("err_code", 32'(bus.err_code), 32'(e.code));
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd_,
                      input logic [4:0] rs1_, input logic [4:0] rs2_, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im,
                      input logic [31:0] ei, input logic [1:0] ec);
    bit ok;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.fmt = f; bus.opcode = op; bus.rd = rd_; bus.rs1 = rs1_; bus.rs2 = rs2_;
    bus.funct3 = f3; bus.funct7 = f7; bus.imm = im;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back('{ei, exp_addr, ec != 2'd0, ec});
        exp_addr = exp_addr + AW'(4);
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic stall_check(input logic [31:0] ei, input logic [AW-1:0] ea);
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_inst", bus.out_inst, ei);
      chk("stall_addr", 32'(bus.out_addr), 32'(ea));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] a0;
    bus.in_valid = 1'b0; bus.fmt = '0; bus.opcode = '0; bus.rd = '0; bus.rs1 = '0;
    bus.rs2 = '0; bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0; bus.out_ready = 1'b1;

    #12;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_inst", bus.out_inst, 32'd0);
    chk("rst_addr", 32'(bus.out_addr), 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // fmt op rd rs1 rs2 f3 f7 imm -> expected inst, code
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 2'd0);
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,         32'h0020_A423, 2'd0);
    drain();
    chk("err_cnt_clean", 32'(bus.err_cnt), 32'd0);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 2'd0);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,         32'h0000_0163, 2'd2);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,      32'h8000_0063, 2'd1);
    drain();
    chk("err_cnt_b", 32'(bus.err_cnt), 32'd2);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,         32'h0080_00EF, 2'd0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 2'd0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h1234_52B7, 2'd1);
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 2'd0);
    send(3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,        32'h0000_0013, 2'd3);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h8000_0093, 2'd1);
    send(3'd2, 7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F7FF, 32'h7E00_0FA3, 2'd1);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h8000_00EF, 2'd1);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,         32'h0000_00EF, 2'd2);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001, 32'h8000_0063, 2'd2);
    drain();
    chk("err_cnt_mix", 32'(bus.err_cnt), 32'd9);

    // Backpressure: three back-to-back words against a 3-cycle stall.
    a0 = exp_addr;
    bus.out_ready = 1'b0;
    fork
      begin
        send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0113, 2'd0);
        send(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0193, 2'd0);
        send(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0030_0213, 2'd0);
      end
      stall_check(32'h0010_0113, a0);
    join
    drain();

    // Saturation of the error counter.
    for (int i = 0; i < 250; i++)
      send(3'd7, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 2'd3);
    drain();
    chk("err_cnt_sat", 32'(bus.err_cnt), 32'd255);

    // clear during a stall discards the pending word.
    bus.out_ready = 1'b0;
    send(3'd7, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 2'd3);
    clear = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("clear_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    q.delete();
    exp_addr = '0;
    chk("clear_valid", 32'(bus.out_valid), 32'd0);
    chk("clear_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("clear_addr", 32'(bus.out_addr), 32'd0);

    // Address wrap with a 4-bit counter: 0,4,8,12,0.
    for (int i = 0; i < 5; i++)
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), {12'(i), 20'h00093}, 2'd0);
    drain();
    chk("wrap_addr", 32'(bus.out_addr), 32'd4);

    // Asynchronous reset mid-stream.
    send(3'd6, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 2'd3);
    drain();
    chk("pre_rst_err_cnt", 32'(bus.err_cnt), 32'd1);
    bus.out_ready = 1'b0;
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0000_00EF, 2'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_inst", bus.out_inst, 32'd0);
    chk("arst_err", 32'(bus.out_err), 32'd0);
    chk("arst_code", 32'(bus.err_code), 32'd0);
    chk("arst_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("arst_addr", 32'(bus.out_addr), 32'd0);
    q.delete();
    exp_addr = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 2'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
